extract_seq: RTL

Sequencer that shares one registered byte-extraction mux across the programmable field list of a parser stage. It accepts a header window plus a header-type tag, walks the per-type offset list stored in an internal config table, and issues one offset per cycle to the mux. It packs the returned bytes into a field vector and hands it downstream with a valid/ready handshake. It sits between the header-window buffer and the key-build/lookup stage of each parser pipeline stage.

---
 rtl/extract_seq_pkg.sv | 28 ++
 rtl/extract_field_mux.sv | 46 ++++
 rtl/extract_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/extract_seq_pkg.sv
// Shared types and constants for the extract_seq parser-stage sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The DEF_* values mirror the default module parameters; the typedefs are
// sized from them and describe the default build.
package extract_seq_pkg;

    localparam int DEF_CANDI_NUM     = 128;
    localparam int DEF_OFFSET_WIDTH  = 7;
    localparam int DEF_EXTRACT_WIDTH = 8;
    localparam int DEF_FIELD_NUM     = 8;

    localparam int IDX_WIDTH   = $clog2(DEF_FIELD_NUM);
    // Top bit of a config offset entry marks the entry as valid.
    localparam int OFF_VLD_BIT = DEF_OFFSET_WIDTH;

    typedef logic [DEF_OFFSET_WIDTH:0]    offset_t;
    typedef logic [DEF_EXTRACT_WIDTH-1:0] field_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/extract_field_mux.sv
// CANDI_NUM:1 byte-extraction mux with valid-bit/range gate and output register.
// Latency: 1 cycle from i_offset to o_field.
// Backpressure: none; samples every cycle.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_data header window
// (byte 0 in LSBs); i_offset {valid, index}; o_field registered extracted byte.
module extract_field_mux #(
    parameter int CANDI_NUM     = 128,
    parameter int OFFSET_WIDTH  = 7,
    parameter int EXTRACT_WIDTH = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [CANDI_NUM*EXTRACT_WIDTH-1:0] i_data,
    input  logic [OFFSET_WIDTH:0]              i_offset,
    output logic [EXTRACT_WIDTH-1:0]           o_field
);

    logic [CANDI_NUM-1:0][EXTRACT_WIDTH-1:0] win;
    logic [OFFSET_WIDTH-1:0]                 sel;
    logic                                    in_range;
    logic [EXTRACT_WIDTH-1:0]                field_nxt;

    assign win = i_data;
    assign sel = i_offset[OFFSET_WIDTH-1:0];

    // Only a window narrower than the offset space can be indexed past its end.
    generate
        if (CANDI_NUM < (1 << OFFSET_WIDTH)) begin : g_range_chk
            assign in_range = (int'(sel) < CANDI_NUM);
        end else begin : g_no_range_chk
            assign in_range = 1'b1;
        end
    endgenerate

    assign field_nxt = (i_offset[OFFSET_WIDTH] && in_range) ? win[sel] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_field <= '0;
        end else begin
            o_field <= field_nxt;
        end
    end

endmodule

// File: rtl/extract_seq.sv
// Walks a per-header-type offset list through one shared byte mux and packs the fields.
// Latency: request accepted at edge T -> o_out_valid at edge T+FIELD_NUM+1.
// Backpressure: o_req_ready only in IDLE; result held in DONE until i_out_ready.
//
// Ports: i_cfg_* config table write (dropped with o_cfg_err pulse while busy);
// i_req_* request handshake with header window and type; o_out_valid/i_out_ready
// result handshake with o_out_type and o_fields (field 0 in LSBs); o_busy = not IDLE.
module extract_seq
    import extract_seq_pkg::*;
#(
    parameter int CANDI_NUM     = 128,
    parameter int OFFSET_WIDTH  = 7,
    parameter int EXTRACT_WIDTH = 8,
    parameter int FIELD_NUM     = 8,
    parameter int TYPE_NUM      = 4,
    parameter int TYPE_WIDTH    = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_cfg_wr,
    input  logic [TYPE_WIDTH-1:0]              i_cfg_type,
    input  logic [$clog2(FIELD_NUM)-1:0]       i_cfg_idx,
    input  logic [OFFSET_WIDTH:0]              i_cfg_offset,
    output logic                               o_cfg_err,
    input  logic                               i_req_valid,
    output logic                               o_req_ready,
    input  logic [TYPE_WIDTH-1:0]              i_req_type,
    input  logic [CANDI_NUM*EXTRACT_WIDTH-1:0] i_req_data,
    output logic                               o_out_valid,
    input  logic                               i_out_ready,
    output logic [TYPE_WIDTH-1:0]              o_out_type,
    output logic [FIELD_NUM*EXTRACT_WIDTH-1:0] o_fields,
    output logic                               o_busy
);

    localparam int IDX_W = $clog2(FIELD_NUM);

    state_t state_q, state_d;
    logic   accept;

    logic [CANDI_NUM*EXTRACT_WIDTH-1:0]      data_q;
    logic [TYPE_WIDTH-1:0]                   type_q;
    logic [IDX_W-1:0]                        idx_q;
    logic [IDX_W-1:0]                        idx_d_q;
    logic                                    wr_pend_q;
    logic [FIELD_NUM-1:0][EXTRACT_WIDTH-1:0] fields_q;
    logic                                    out_valid_q;
    logic                                    cfg_err_q;

    logic [OFFSET_WIDTH:0]    cfg_tbl [TYPE_NUM][FIELD_NUM];
    logic [OFFSET_WIDTH:0]    cur_offset;
    logic [EXTRACT_WIDTH-1:0] mux_field;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_req_ready = 1'b0;
        o_busy      = 1'b1;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_req_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (idx_q == IDX_W'(FIELD_NUM - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                // Exit only; a request seen here waits for IDLE.
                if (i_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- config table
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int t = 0; t < TYPE_NUM; t++) begin
                for (int f = 0; f < FIELD_NUM; f++) begin
                    cfg_tbl[t][f] <= '0;
                end
            end
            cfg_err_q <= 1'b0;
        end else begin
            // The table is frozen while a request walks it, so results never mix rows.
            if (i_cfg_wr && !o_busy) begin
                cfg_tbl[i_cfg_type][i_cfg_idx] <= i_cfg_offset;
            end
            cfg_err_q <= i_cfg_wr && o_busy;
        end
    end

    assign cur_offset = cfg_tbl[type_q][idx_q];

    // ---------------------------------------------------------------- shared mux
    extract_field_mux #(
        .CANDI_NUM     (CANDI_NUM),
        .OFFSET_WIDTH  (OFFSET_WIDTH),
        .EXTRACT_WIDTH (EXTRACT_WIDTH)
    ) u_mux (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_data   (data_q),
        .i_offset (cur_offset),
        .o_field  (mux_field)
    );

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q      <= '0;
            type_q      <= '0;
            idx_q       <= '0;
            idx_d_q     <= '0;
            wr_pend_q   <= 1'b0;
            fields_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // The mux output lags its offset by a cycle, so the write slot
            // follows the issued index one cycle behind.
            wr_pend_q <= (state_q == ISSUE);
            idx_d_q   <= idx_q;

            if (accept) begin
                data_q   <= i_req_data;
                type_q   <= i_req_type;
                idx_q    <= '0;
                fields_q <= '0;
            end else if (state_q == ISSUE) begin
                idx_q <= idx_q + IDX_W'(1);
            end

            if (wr_pend_q) begin
                fields_q[idx_d_q] <= mux_field;
            end

            if (state_q == DRAIN) begin
                out_valid_q <= 1'b1;
            end else if ((state_q == DONE) && i_out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign o_out_valid = out_valid_q;
    assign o_out_type  = type_q;
    assign o_fields    = fields_q;
    assign o_cfg_err   = cfg_err_q;

endmodule
